fifo_stream_reader: RTL and testbench

//  Read-side controller for fifo_sync. Drains words through the FIFO read port (rd_en/dout/empty)
//  and presents them as a valid/ready stream with burst framing (m_last every BURST_LEN beats).

---
 rtl/fifo_stream_reader.sv | 71 +++++++
 tb/tb_fifo_stream_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side controller for fifo_sync: issues FIFO reads, absorbs the registered read latency
// in a 2-entry buffer and presents the words as a valid/ready stream with burst framing.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_W-1:0]      xfer_cnt
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_reg [2];
  logic [1:0]            buf_cnt_reg;
  logic                  inflight_reg;
  logic [BEAT_W-1:0]     beat_cnt_reg;
  logic [CNT_W-1:0]      xfer_cnt_reg;

  logic                  pop;
  logic [2:0]            occ_next;
  logic [1:0]            wr_idx;

  assign m_valid  = (buf_cnt_reg != 2'd0);
  assign m_data   = buf_reg[0];
  assign m_last   = m_valid & (beat_cnt_reg == LAST_BEAT);
  assign xfer_cnt = xfer_cnt_reg;
  assign pop      = m_valid & m_ready;

  // Occupancy after this edge if nothing new is issued; a read is allowed only if
  // its word is guaranteed a free slot when it lands.
  assign occ_next   = {1'b0, buf_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign fifo_rd_en = !rst & en & !fifo_empty & (occ_next < 3'd2);

  // Tail slot for the landing word, after the head has shifted out on a pop.
  assign wr_idx = buf_cnt_reg - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_reg[0]   <= '0;
      buf_reg[1]   <= '0;
      buf_cnt_reg  <= 2'd0;
      inflight_reg <= 1'b0;
      beat_cnt_reg <= '0;
      xfer_cnt_reg <= '0;
    end else begin
      inflight_reg <= fifo_rd_en;
      buf_cnt_reg  <= buf_cnt_reg - {1'b0, pop} + {1'b0, inflight_reg};
      if (pop) begin
        buf_reg[0]   <= buf_reg[1];
        xfer_cnt_reg <= xfer_cnt_reg + CNT_W'(1);
        beat_cnt_reg <= (beat_cnt_reg == LAST_BEAT) ? '0 : beat_cnt_reg + BEAT_W'(1);
      end
      // Later assignment wins, so a capture into slot 0 overrides the shift.
      if (inflight_reg) begin
        buf_reg[wr_idx[0]] <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural fifo_sync model, queue scoreboard of written words,
// burst position and transfer count derived from the observed handshakes.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          en;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [CW-1:0] xfer_cnt;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .xfer_cnt   (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // fifo_sync model: writes land at the edge, reads return data one cycle after rd_en.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] wr_pend[$];
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      wr_pend.delete();
      fifo_dout <= '0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      while (wr_pend.size() > 0) fq.push_back(wr_pend.pop_front());
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Scoreboard: every written word must come out once, in order.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;
  int  beat_idx = 0, pop_total = 0, rd_total = 0;
  int  hold_viol = 0, under_viol = 0, occ_viol = 0, spur_viol = 0, rst_rd_viol = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (fifo_rd_en) rst_rd_viol++;
      beat_idx = 0; pop_total = 0; rd_total = 0;
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_data !== prev_data)) hold_viol++;
      if (fifo_rd_en && fifo_empty) under_viol++;
      if (rd_total - pop_total > 2) occ_viol++;
      if (fifo_rd_en) rd_total++;
      if (m_valid && m_ready) begin
        $display("beat %0d data=%02h last=%0b xfer=%0d", pop_total, m_data, m_last, xfer_cnt);
        if (exp_q.size() == 0) spur_viol++;
        else begin
          exp_d = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(exp_d));
        end
        check("beat_last", 32'(m_last), 32'((beat_idx % BL) == BL - 1));
        check("beat_xfer", 32'(xfer_cnt), 32'(pop_total % (1 << CW)));
        beat_idx++;
        pop_total++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_pend.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget, input bit rand_ready);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  int t0, vcnt, nxt, guard, r0;

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last",  32'(m_last),  32'd0);
    check("rst_xfer",  32'(xfer_cnt), 32'd0);
    check("rst_data",  32'(m_data),  32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

    // T1: 15 bytes at full rate
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 15; i++) write_word(8'(8'h10 + i));
    guard = 0;
    while (!fifo_rd_en && guard < 20) begin step(); guard++; end
    t0 = cyc;
    guard = 0;
    while (!m_valid && guard < 20) begin step(); guard++; end
    check("t1_latency", 32'(cyc - t0), 32'd2);
    vcnt = 0;
    while (m_valid && vcnt < 40) begin vcnt++; step(); end
    check("t1_contig", 32'(vcnt), 32'd15);
    repeat (3) step();
    check("t1_xfer",  32'(xfer_cnt), 32'd15);
    check("t1_empty", 32'(fifo_empty), 32'd1);
    check("t1_idle",  32'(m_valid), 32'd0);
    check("t1_left",  32'(exp_q.size()), 32'd0);

    // T2: sink stall with 8 words waiting
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'(8'h10 + i));
    repeat (10) step();
    check("t2_stall_reads", 32'(rd_total), 32'd2);
    check("t2_hold_data",   32'(m_data), 32'h10);
    check("t2_hold_valid",  32'(m_valid), 32'd1);
    m_ready = 1'b1;
    wait_drain("t2", 100, 1'b0);
    check("t2_xfer", 32'(xfer_cnt), 32'd8);

    // T3: random writes and random backpressure
    do_reset();
    en = 1'b1;
    nxt = 0; guard = 0;
    while (nxt < 64 && guard < 2000) begin
      if ($urandom_range(0, 1) == 1) begin write_word(8'(nxt)); nxt++; end
      m_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    wait_drain("t3", 2000, 1'b1);
    check("t3_xfer", 32'(xfer_cnt), 32'd64);

    // T4: en gap after the third read
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) write_word(8'(8'h40 + i));
    guard = 0;
    while (rd_total < 3 && guard < 20) begin step(); guard++; end
    en = 1'b0;
    r0 = rd_total;
    repeat (5) step();
    check("t4_gap_reads", 32'(rd_total - r0), 32'd0);
    check("t4_gap_beats", 32'(pop_total), 32'd3);
    check("t4_gap_idle",  32'(m_valid), 32'd0);
    en = 1'b1;
    wait_drain("t4", 100, 1'b0);
    check("t4_xfer", 32'(xfer_cnt), 32'd8);

    // T5: reset with a word buffered and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(8'(8'h50 + i));
    guard = 0;
    while (!m_valid && guard < 20) begin step(); guard++; end
    check("t5_pre_valid", 32'(m_valid), 32'd1);
    check("t5_pre_xfer",  32'(xfer_cnt), 32'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_last",  32'(m_last), 32'd0);
    check("t5_xfer",  32'(xfer_cnt), 32'd0);
    check("t5_rd_en", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) write_word(8'(8'h60 + i));
    wait_drain("t5", 100, 1'b0);
    check("t5_xfer_after", 32'(xfer_cnt), 32'd4);

    // T6: single word
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    write_word(8'h77);
    repeat (12) step();
    check("t6_reads", 32'(rd_total), 32'd1);
    check("t6_beats", 32'(pop_total), 32'd1);
    check("t6_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t6_idle",  32'(m_valid), 32'd0);
    check("t6_empty", 32'(fifo_empty), 32'd1);
    check("t6_xfer",  32'(xfer_cnt), 32'd1);

    check("underflow_reads", 32'(under_viol), 32'd0);
    check("occupancy",       32'(occ_viol), 32'd0);
    check("stall_hold",      32'(hold_viol), 32'd0);
    check("spurious_beats",  32'(spur_viol), 32'd0);
    check("rd_en_in_reset",  32'(rst_rd_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
